// File: rtl/bcd_key_entry.sv
// rtl/bcd_key_entry.sv - keypad digit collector feeding the BCD-to-binary converter
// Optional idle auto-commit is built when AUTO_COMMIT_EN is defined.
module bcd_key_entry #(
   parameter logic [3:0]  KEY_ENTER      = 4'hE,
   parameter logic [3:0]  KEY_CLEAR      = 4'hC,
   parameter int unsigned TIMEOUT_CYCLES = 27_000_000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_key_valid,
   input  logic [3:0] i_key_code,
   output logic [3:0] o_d2,
   output logic [3:0] o_d1,
   output logic [3:0] o_d0,
   output logic       o_en,
   output logic [1:0] o_ndigits,
   output logic       o_ovf
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ENTRY = 2'd1,
      S_FULL  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_d2;
   logic [3:0] r_d1;
   logic [3:0] r_d0;
   logic [3:0] w_d2_nxt;
   logic [3:0] w_d1_nxt;
   logic [3:0] w_d0_nxt;
   logic [1:0] r_ndigits;
   logic [1:0] w_ndigits_nxt;
   logic       r_en;
   logic       w_en_nxt;
   logic       r_ovf;
   logic       w_ovf_nxt;
   logic       w_is_digit;
   logic       w_pending;
   logic       w_timeout;

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   assign w_is_digit = (i_key_code <= 4'd9);
   assign w_pending  = (r_state == S_ENTRY) || (r_state == S_FULL);

`ifdef AUTO_COMMIT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_accept;

   // Rejected digits (buffer full) and ignored codes leave the idle count untouched.
   assign w_accept = i_key_valid &&
                     ((i_key_code == KEY_CLEAR) ||
                      ((i_key_code == KEY_ENTER) && w_pending) ||
                      (w_is_digit && (r_state != S_FULL)));

   assign w_timeout = w_pending && !i_key_valid &&
                      (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (!w_pending || w_accept || w_timeout) begin
         r_cnt <= '0;
      end else if (!i_key_valid) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_EMPTY;
         r_d2      <= 4'd0;
         r_d1      <= 4'd0;
         r_d0      <= 4'd0;
         r_ndigits <= 2'd0;
         r_en      <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_d2      <= w_d2_nxt;
         r_d1      <= w_d1_nxt;
         r_d0      <= w_d0_nxt;
         r_ndigits <= w_ndigits_nxt;
         r_en      <= w_en_nxt;
         r_ovf     <= w_ovf_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_d2_nxt      = r_d2;
      w_d1_nxt      = r_d1;
      w_d0_nxt      = r_d0;
      w_ndigits_nxt = r_ndigits;
      w_en_nxt      = 1'b0;
      w_ovf_nxt     = 1'b0;

      if (i_key_valid) begin
         if (i_key_code == KEY_CLEAR) begin
            w_state_nxt   = S_EMPTY;
            w_d2_nxt      = 4'd0;
            w_d1_nxt      = 4'd0;
            w_d0_nxt      = 4'd0;
            w_ndigits_nxt = 2'd0;
         end else if (i_key_code == KEY_ENTER) begin
            // Nothing to commit when empty; no repeat commit once done.
            if (w_pending) begin
               w_en_nxt    = 1'b1;
               w_state_nxt = S_DONE;
            end
         end else if (w_is_digit) begin
            case (r_state)
               S_FULL: begin
                  w_ovf_nxt = 1'b1;
               end
               S_DONE: begin
                  w_d2_nxt      = 4'd0;
                  w_d1_nxt      = 4'd0;
                  w_d0_nxt      = i_key_code;
                  w_ndigits_nxt = 2'd1;
                  w_state_nxt   = S_ENTRY;
               end
               default: begin
                  w_d2_nxt      = r_d1;
                  w_d1_nxt      = r_d0;
                  w_d0_nxt      = i_key_code;
                  w_ndigits_nxt = r_ndigits + 2'd1;
                  w_state_nxt   = (r_ndigits == 2'd2) ? S_FULL : S_ENTRY;
               end
            endcase
         end
      end else if (w_timeout) begin
         w_en_nxt    = 1'b1;
         w_state_nxt = S_DONE;
      end
   end

   assign o_d2      = r_d2;
   assign o_d1      = r_d1;
   assign o_d0      = r_d0;
   assign o_en      = r_en;
   assign o_ndigits = r_ndigits;
   assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_bcd_key_entry.sv
// tb/tb_bcd_key_entry.sv - self-checking bench for bcd_key_entry
// Idle auto-commit checks are built when AUTO_COMMIT_EN is defined.
module tb_bcd_key_entry;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       kv = 1'b0;
   logic [3:0] kc = 4'd0;
   logic [3:0] d2, d1, d0;
   logic       en, ovf;
   logic [1:0] nd;

   bcd_key_entry #(.TIMEOUT_CYCLES(TO)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_key_valid(kv), .i_key_code(kc),
      .o_d2(d2), .o_d1(d1), .o_d0(d0), .o_en(en), .o_ndigits(nd), .o_ovf(ovf)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;

   // Reference model: the entry is just a list of typed digits plus a committed flag.
   int m_q[$];
   bit m_done, m_en, m_ovf;
   int m_idle;

   typedef struct {
      bit v; logic [3:0] c;
      int e2; int e1; int e0; int een; int end_; int eovf;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic int mdig(input int k);
      if (m_q.size() > k) return m_q[m_q.size() - 1 - k];
      return 0;
   endfunction

   task automatic model_reset();
      m_q.delete(); m_done = 0; m_en = 0; m_ovf = 0; m_idle = 0;
   endtask

   task automatic model_step(input bit v, input logic [3:0] c);
      bit acc;
      acc = 0; m_en = 0; m_ovf = 0;
      if (v) begin
         if (c == 4'hC) begin
            m_q.delete(); m_done = 0; acc = 1;
         end else if (c == 4'hE) begin
            if (!m_done && m_q.size() > 0) begin m_en = 1; m_done = 1; acc = 1; end
         end else if (c <= 4'd9) begin
            if (m_done) begin m_q.delete(); m_q.push_back(int'(c)); m_done = 0; acc = 1; end
            else if (m_q.size() == 3) m_ovf = 1;
            else begin m_q.push_back(int'(c)); acc = 1; end
         end
      end
`ifdef AUTO_COMMIT_EN
      if (m_done || m_q.size() == 0 || acc) m_idle = 0;
      else if (!v) begin
         m_idle++;
         if (m_idle == TO) begin m_en = 1; m_done = 1; m_idle = 0; end
      end
`endif
   endtask

   task automatic cycle(input bit v, input logic [3:0] c);
      kv = v; kc = c;
      @(posedge clk); #1;
      model_step(v, c);
   endtask

   task automatic check_model(input string tag);
      chk({tag, " d2"}, int'(d2), mdig(2));
      chk({tag, " d1"}, int'(d1), mdig(1));
      chk({tag, " d0"}, int'(d0), mdig(0));
      chk({tag, " ndigits"}, int'(nd), m_q.size());
      chk({tag, " en"}, int'(en), int'(m_en));
      chk({tag, " ovf"}, int'(ovf), int'(m_ovf));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " d2"}, int'(d2), 0);
      chk({tag, " d1"}, int'(d1), 0);
      chk({tag, " d0"}, int'(d0), 0);
      chk({tag, " ndigits"}, int'(nd), 0);
      chk({tag, " en"}, int'(en), 0);
      chk({tag, " ovf"}, int'(ovf), 0);
   endtask

   function automatic vec_t mk(input bit v, input logic [3:0] c, input int e2, input int e1,
                               input int e0, input int nd_e, input int en_e, input int ovf_e);
      vec_t r;
      r.v = v; r.c = c; r.e2 = e2; r.e1 = e1; r.e0 = e0;
      r.end_ = nd_e; r.een = en_e; r.eovf = ovf_e;
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int en_cnt, first_en;
      string tag;
      logic [3:0] rc;
      bit rv;

      // Rows: valid, code, expected d2, d1, d0, ndigits, en, ovf
      tbl.push_back(mk(1, 4'h1, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(1, 4'h2, 0, 1, 2, 2, 0, 0));
      tbl.push_back(mk(1, 4'h3, 1, 2, 3, 3, 0, 0));
      tbl.push_back(mk(1, 4'hE, 1, 2, 3, 3, 1, 0));
      tbl.push_back(mk(0, 4'h5, 1, 2, 3, 3, 0, 0));
      tbl.push_back(mk(1, 4'h4, 0, 0, 4, 1, 0, 0));
      tbl.push_back(mk(1, 4'h5, 0, 4, 5, 2, 0, 0));
      tbl.push_back(mk(1, 4'hE, 0, 4, 5, 2, 1, 0));
      tbl.push_back(mk(1, 4'h7, 0, 0, 7, 1, 0, 0));
      tbl.push_back(mk(1, 4'hC, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 4'h9, 0, 0, 9, 1, 0, 0));
      tbl.push_back(mk(1, 4'h9, 0, 9, 9, 2, 0, 0));
      tbl.push_back(mk(1, 4'h9, 9, 9, 9, 3, 0, 0));
      tbl.push_back(mk(1, 4'h8, 9, 9, 9, 3, 0, 1));
      tbl.push_back(mk(0, 4'h8, 9, 9, 9, 3, 0, 0));
      tbl.push_back(mk(1, 4'hC, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 4'hE, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 4'hA, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 4'h5, 0, 0, 5, 1, 0, 0));
      tbl.push_back(mk(1, 4'hF, 0, 0, 5, 1, 0, 0));
      tbl.push_back(mk(1, 4'hE, 0, 0, 5, 1, 1, 0));
      tbl.push_back(mk(1, 4'hE, 0, 0, 5, 1, 0, 0));
      tbl.push_back(mk(1, 4'hE, 0, 0, 5, 1, 0, 0));
      tbl.push_back(mk(0, 4'h3, 0, 0, 5, 1, 0, 0));
      tbl.push_back(mk(1, 4'h0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 4'h0, 0, 0, 0, 2, 0, 0));
      tbl.push_back(mk(1, 4'h7, 0, 0, 7, 3, 0, 0));
      tbl.push_back(mk(1, 4'hE, 0, 0, 7, 3, 1, 0));
      tbl.push_back(mk(1, 4'h4, 0, 0, 4, 1, 0, 0));
      tbl.push_back(mk(1, 4'hB, 0, 0, 4, 1, 0, 0));

      // Asynchronous reset asserted mid-cycle must clear outputs immediately.
      #2 rst_n = 1'b0;
      #1 check_zero("reset");
      model_reset();
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i].v, tbl[i].c);
         tag = $sformatf("vec%0d", i);
         chk({tag, " d2"}, int'(d2), tbl[i].e2);
         chk({tag, " d1"}, int'(d1), tbl[i].e1);
         chk({tag, " d0"}, int'(d0), tbl[i].e0);
         chk({tag, " ndigits"}, int'(nd), tbl[i].end_);
         chk({tag, " en"}, int'(en), tbl[i].een);
         chk({tag, " ovf"}, int'(ovf), tbl[i].eovf);
      end

      // Reset in the middle of an entry discards it and produces no commit.
      cycle(1, 4'hC); cycle(1, 4'h1); cycle(1, 4'h2);
      check_model("pre_reset");
      #3 rst_n = 1'b0;
      #1 check_zero("mid_entry_reset");
      model_reset();
      @(posedge clk); #1 rst_n = 1'b1;
      cycle(0, 4'h0);
      check_model("post_reset");
      cycle(1, 4'hE);
      check_model("enter_after_reset");

      for (int i = 0; i < 1500; i++) begin
         rv = ($urandom_range(0, 9) < 6);
         rc = 4'($urandom_range(0, 15));
         cycle(rv, rc);
         check_model($sformatf("rand%0d", i));
      end

      cycle(1, 4'hC); cycle(1, 4'h6);
`ifdef AUTO_COMMIT_EN
      first_en = -1;
      for (int i = 1; i <= 20; i++) begin
         cycle(0, 4'h0);
         check_model($sformatf("to_a%0d", i));
         if (en && first_en < 0) first_en = i;
      end
      chk("timeout_commit_cycle", first_en, TO);
      chk("timeout_digit", int'(d0), 6);

      cycle(1, 4'hC); cycle(1, 4'h6);
      for (int i = 1; i <= 10; i++) begin
         cycle(0, 4'h0);
         chk($sformatf("to_b%0d early en", i), int'(en), 0);
      end
      cycle(1, 4'h7);
      first_en = -1;
      for (int i = 1; i <= 20; i++) begin
         cycle(0, 4'h0);
         check_model($sformatf("to_c%0d", i));
         if (en && first_en < 0) first_en = i;
      end
      chk("timeout_restart_cycle", first_en, TO);
      chk("timeout_restart_value", int'(d1) * 10 + int'(d0), 67);
`else
      en_cnt = 0;
      for (int i = 1; i <= 100; i++) begin
         cycle(0, 4'h0);
         check_model($sformatf("idle%0d", i));
         if (en) en_cnt++;
      end
      chk("no_auto_commit", en_cnt, 0);
      chk("idle_digit_kept", int'(d0), 6);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
